// File: rtl/poly_add_ctrl_pkg.sv
// Shared Kyber parameters and the controller state encoding.
//   KYBER_Q        : coefficient modulus
//   KYBER_DATA_WID : coefficient width
//   KYBER_N        : coefficients per polynomial
//   KYBER_ADDR_WID : log2(KYBER_N)
//   state_t        : poly_add_ctrl sequencing states
package poly_add_ctrl_pkg;

    localparam int KYBER_Q        = 3329;
    localparam int KYBER_DATA_WID = 12;
    localparam int KYBER_N        = 256;
    localparam int KYBER_ADDR_WID = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/poly_add_ctrl_cla_adder.sv
// Carry-lookahead adder used for the stage-2 coefficient addition.
//   a, b : DATA_WID-bit operands
//   cin  : carry in
//   sum  : DATA_WID+1-bit result (carry out in the MSB)
module cla_adder #(
    parameter int DATA_WID = 12
) (
    input  logic [DATA_WID-1:0] a,
    input  logic [DATA_WID-1:0] b,
    input  logic                cin,
    output logic [DATA_WID:0]   sum
);

    logic [DATA_WID-1:0] g;
    logic [DATA_WID-1:0] p;
    logic [DATA_WID:0]   carry;
    logic                pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded fully from generate/propagate terms rather than
    // chained through the previous carry.
    always_comb begin
        carry    = '0;
        pp       = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < DATA_WID; i++) begin
            carry[i+1] = g[i];
            pp         = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (pp & g[j]);
                pp         = pp & p[j];
            end
            carry[i+1] = carry[i+1] | (pp & cin);
        end
    end

    assign sum = {carry[DATA_WID], p ^ carry[DATA_WID-1:0]};

endmodule

// File: rtl/poly_add_ctrl.sv
// Streams two source polynomials through a 3-stage modular add/subtract
// pipeline and writes the reduced result polynomial.
//   clk, rst_n           : clock, async active-low reset
//   start, mode          : one-cycle request; mode 0 = a+b, 1 = a-b (mod Q)
//   stall                : suppresses new read issue
//   busy, done           : operation in progress / one-cycle completion
//   rd_en, rd_addr       : shared read strobe/address to both sources
//   rd_data_a, rd_data_b : operands, valid the cycle after rd_en
//   wr_en, wr_addr, wr_data : result write port
module poly_add_ctrl
    import poly_add_ctrl_pkg::*;
#(
    parameter int DATA_WID = KYBER_DATA_WID,
    parameter int N        = KYBER_N,
    parameter int Q        = KYBER_Q,
    parameter int ADDR_WID = KYBER_ADDR_WID
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_WID-1:0] rd_addr,
    input  logic [DATA_WID-1:0] rd_data_a,
    input  logic [DATA_WID-1:0] rd_data_b,
    output logic                wr_en,
    output logic [ADDR_WID-1:0] wr_addr,
    output logic [DATA_WID-1:0] wr_data
);

    localparam int STAGES = 3;

    state_t                state;
    logic                  mode_q;
    logic [ADDR_WID-1:0]   addr_cnt;
    logic                  issue;
    logic                  last_issue;
    logic [STAGES:1]       vld_pipe;
    logic [ADDR_WID-1:0]   addr_p1;
    logic [ADDR_WID-1:0]   addr_p2;
    logic [DATA_WID-1:0]   a_q;
    logic [DATA_WID-1:0]   b_q;
    logic [DATA_WID-1:0]   op_b;
    logic [DATA_WID:0]     sum;
    logic [DATA_WID:0]     diff;
    logic [DATA_WID-1:0]   red;

    // Stall gates the strobe in the same cycle so the address counter simply
    // holds; nothing already in the pipeline is affected.
    assign issue      = (state == ST_ISSUE) && !stall;
    assign last_issue = issue && (addr_cnt == ADDR_WID'(N - 1));
    assign rd_en      = issue;
    assign rd_addr    = addr_cnt;
    assign wr_en      = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            addr_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        addr_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (last_issue) begin
                        addr_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else if (issue) begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Final write is on the port and nothing else in flight.
                    if (vld_pipe == 3'b100) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 2: a + b, or a + (Q - b) for subtract, then one conditional -Q.
    assign op_b = mode_q ? (DATA_WID'(Q) - b_q) : b_q;

    cla_adder #(.DATA_WID(DATA_WID)) u_cla_adder (
        .a   (a_q),
        .b   (op_b),
        .cin (1'b0),
        .sum (sum)
    );

    assign diff = sum - (DATA_WID+1)'(Q);
    assign red  = (sum >= (DATA_WID+1)'(Q)) ? diff[DATA_WID-1:0]
                                            : sum[DATA_WID-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            addr_p1  <= '0;
            addr_p2  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            addr_p1  <= addr_cnt;
            if (vld_pipe[1]) begin
                a_q     <= rd_data_a;
                b_q     <= rd_data_b;
                addr_p2 <= addr_p1;
            end
            if (vld_pipe[2]) begin
                wr_data <= red;
                wr_addr <= addr_p2;
            end
        end
    end

endmodule

// File: tb/tb_poly_add_ctrl.sv
module tb_poly_add_ctrl;

    localparam int N  = 256;
    localparam int Q  = 3329;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic        stall;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data_a = '0;
    logic [11:0] rd_data_b = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndone = 0;
    int mem_a [N];
    int mem_b [N];
    int wa_q [$];
    int wd_q [$];
    int wc_q [$];

    poly_add_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memories: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= 12'(mem_a[rd_addr]);
            rd_data_b <= 12'(mem_b[rd_addr]);
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(int'(wr_data));
            wc_q.push_back(cyc);
        end
        if (done) ndone++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model(input int a, input int b, input bit md);
        if (md) return (a - b + Q) % Q;
        return (a + b) % Q;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = $urandom_range(Q - 1, 0);
            mem_b[i] = $urandom_range(Q - 1, 0);
        end
    endtask

    // Called right after a posedge (#1). Start is raised in the current cycle
    // T; returns in the cycle done is seen, without advancing further, so a
    // following call starts back-to-back.
    task automatic run_op(input bit md, input int st_lo, input int st_hi,
                          input bit poke, input int exp_done);
        int  t0;
        bit  seen;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        t0    = cyc;
        start = 1'b1;
        mode  = md;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'($urandom);
        chk("busy_rise", int'(busy), 1);
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            stall = (cyc - t0 >= st_lo) && (cyc - t0 <= st_hi);
            start = poke && (cyc - t0 == 50);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("done_cycle", cyc - t0, exp_done);
        chk("busy_at_done", int'(busy), 0);
        chk("wr_count", wa_q.size(), N);
        for (int i = 0; i < wa_q.size() && i < N; i++) begin
            chk("wr_addr", wa_q[i], i);
            chk("wr_data", wd_q[i], model(mem_a[i], mem_b[i], md));
        end
        if (wc_q.size() > 0) begin
            chk("first_wr", wc_q[0] - t0, 4);
            chk("last_wr", wc_q[wc_q.size()-1] - t0, exp_done - 1);
        end
    endtask

    initial begin
        int t0, nw, nd, lo, len;
        bit md;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add ramp + 3000, nominal timing
        for (int i = 0; i < N; i++) begin mem_a[i] = i; mem_b[i] = 3000; end
        run_op(1'b0, 1, 0, 1'b0, 260);
        repeat (3) @(posedge clk);
        #1;

        // subtract 5 - 10
        for (int i = 0; i < N; i++) begin mem_a[i] = 5; mem_b[i] = 10; end
        run_op(1'b1, 1, 0, 1'b0, 260);

        // boundary add, started in the same cycle done was high
        fill_random();
        mem_a[0] = 3328; mem_b[0] = 1;
        mem_a[1] = 3328; mem_b[1] = 3328;
        mem_a[2] = 0;    mem_b[2] = 0;
        run_op(1'b0, 1, 0, 1'b0, 260);
        repeat (2) @(posedge clk);
        #1;

        // stall window T+10..T+19
        fill_random();
        md = 1'($urandom);
        run_op(md, 10, 19, 1'b0, 270);
        repeat (2) @(posedge clk);
        #1;

        // extra start pulse while busy must be ignored
        fill_random();
        md = 1'($urandom);
        run_op(md, 1, 0, 1'b1, 260);
        repeat (2) @(posedge clk);
        #1;

        // random stall window
        fill_random();
        md  = 1'($urandom);
        lo  = $urandom_range(200, 5);
        len = $urandom_range(20, 1);
        run_op(md, lo, lo + len - 1, 1'b0, 260 + len);
        repeat (5) @(posedge clk);
        #1;
        chk("done_total", ndone, 6);

        // mid-operation reset
        fill_random();
        t0    = cyc;
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 100) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        nw = wa_q.size();
        nd = ndone;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_wr_addr", int'(wr_addr), 0);
        chk("abort_wr_data", int'(wr_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_writes", wa_q.size(), nw);
        chk("abort_no_done", ndone, nd);
        chk("abort_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
